uart_block_assembler: RTL and testbench

// - Sits between the UART byte receiver and initial_transform; packs 32 received bytes

---
 rtl/aes_uart_pkg.sv | 7 +
 rtl/uart_block_assembler.sv | 105 ++++++++++
 tb/tb_uart_block_assembler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared frame sizes, assembler state encoding and block type.
package aes_uart_pkg;
    localparam int BLOCK_BYTES = 16;
    localparam int FRAME_BYTES = 32;
    typedef enum logic [1:0] {S_TEXT, S_KEY, S_HOLD} asm_state_t;
    typedef logic [127:0] aes_block_t;
endpackage

// File: rtl/uart_block_assembler.sv
// uart_block_assembler: packs 32 UART bytes into a 128-bit text/key pair,
// holds the pair until accepted and drops partial frames after an idle timeout.
module uart_block_assembler
    import aes_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output aes_block_t   text,
    output aes_block_t   key,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [4:0] LAST_TEXT = 5'(BLOCK_BYTES - 1);
    localparam logic [4:0] LAST_KEY = 5'(FRAME_BYTES - 1);
    asm_state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    aes_block_t text_q, text_d, key_q, key_d;
    logic ferr_q, ferr_d, ovr_q, ovr_d;
    logic expired;
    assign expired = (TIMEOUT_CYCLES != 0) && (timer_q == T_MAX);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_TEXT;
            cnt_q   <= '0;
            timer_q <= '0;
            text_q  <= '0;
            key_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            text_q  <= text_d;
            key_q   <= key_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        text_d  = text_q;
        key_d   = key_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            S_TEXT, S_KEY: begin
                if (rx_valid) begin
                    if (state_q == S_TEXT) text_d = {text_q[119:0], rx_data};
                    else key_d = {key_q[119:0], rx_data};
                    cnt_d   = cnt_q + 5'd1;
                    timer_d = '0;
                    if (cnt_q == LAST_TEXT) state_d = S_KEY;
                    if (cnt_q == LAST_KEY) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != '0) begin
                    if (expired) begin
                        state_d = S_TEXT;
                        cnt_d   = '0;
                        timer_d = '0;
                        ferr_d  = 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                // A byte arriving with the handshake starts the next frame
                if (blk_ready) begin
                    state_d = S_TEXT;
                    if (rx_valid) begin
                        text_d  = {text_q[119:0], rx_data};
                        cnt_d   = 5'd1;
                        timer_d = '0;
                    end
                end else if (rx_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_TEXT;
        endcase
    end
    always_comb begin
        text      = text_q;
        key       = key_q;
        blk_valid = (state_q == S_HOLD);
        busy      = (cnt_q != '0);
        frame_err = ferr_q;
        overrun   = ovr_q;
    end
endmodule

// File: tb/tb_uart_block_assembler.sv
// tb_uart_block_assembler: directed, table-driven check of frame assembly, hold, timeout and reset.
module tb_uart_block_assembler;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0, blk_ready = 1'b0;
    logic [127:0] text, key;
    logic blk_valid, busy, frame_err, overrun;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    uart_block_assembler #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .text(text), .key(key), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );
    typedef struct {
        logic [7:0] d;
        logic v;
        logic r;
        logic e_valid;
        logic e_busy;
    } vec_t;
    vec_t tbl[33];
    logic [7:0] fa[32] = '{8'h9f, 8'haf, 8'h63, 8'h4b, 8'h37, 8'hec, 8'h39, 8'hfb,
                           8'h51, 8'h8c, 8'h04, 8'hb1, 8'h37, 8'hfa, 8'h66, 8'hd7,
                           8'hcc, 8'h96, 8'hed, 8'h16, 8'h74, 8'hea, 8'haa, 8'h03,
                           8'h1e, 8'h86, 8'h3f, 8'h24, 8'hb2, 8'ha8, 8'h31, 8'h6a};
    logic [7:0] fb[32];
    localparam logic [127:0] TA = 128'h9faf634b37ec39fb518c04b137fa66d7;
    localparam logic [127:0] KA = 128'hcc96ed1674eaaa031e863f24b2a8316a;
    localparam logic [127:0] TB = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KB = 128'h202122232425262728292a2b2c2d2e2f;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    task automatic send(input bit sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rx_data = sel ? fb[i] : fa[i];
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
    endtask
    task automatic handshake();
        blk_ready = 1'b1;
        tick();
        chk("handshake_valid_drop", blk_valid, 0);
        blk_ready = 1'b0;
    endtask
    initial begin
        int ovr_n, ferr_n, ferr_at;
        logic vstay, busy50;
        for (int i = 0; i < 32; i++) fb[i] = 8'(8'h10 + i);
        for (int i = 0; i < 32; i++) tbl[i] = '{fa[i], 1'b1, 1'b1, i == 31, i != 31};
        tbl[32] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tick();
        chk("reset_text", text, 0);
        chk("reset_key", key, 0);
        chk("reset_flags", {blk_valid, busy, frame_err, overrun}, 0);
        rst = 1'b0;
        // frame A, downstream always ready
        for (int i = 0; i < 33; i++) begin
            rx_data = tbl[i].d;
            rx_valid = tbl[i].v;
            blk_ready = tbl[i].r;
            tick();
            chk($sformatf("tbl%0d_valid", i), blk_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_err", i), {frame_err, overrun}, 0);
            if (i == 31) begin
                chk("a_text", text, TA);
                chk("a_key", key, KA);
            end
        end
        rx_valid = 1'b0;
        blk_ready = 1'b0;
        // hold with an extra byte: overrun once, pair untouched
        send(0, 0, 31);
        chk("hold_valid", blk_valid, 1);
        ovr_n = 0;
        vstay = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rx_valid = (k == 5);
            rx_data = 8'h55;
            tick();
            ovr_n += int'(overrun);
            if (!blk_valid) vstay = 1'b0;
        end
        rx_valid = 1'b0;
        chk("hold_overrun_count", ovr_n, 1);
        chk("hold_valid_stable", vstay, 1);
        chk("hold_text", text, TA);
        chk("hold_key", key, KA);
        chk("hold_busy", busy, 0);
        handshake();
        // timeout after 10 bytes
        send(1, 0, 9);
        ferr_n = 0;
        ferr_at = 0;
        busy50 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (frame_err) begin
                ferr_n++;
                ferr_at = k;
            end
            if (k == 50) busy50 = busy;
        end
        chk("to_err_count", ferr_n, 1);
        chk("to_err_cycle", ferr_at, 51);
        chk("to_busy_before", busy50, 1);
        chk("to_busy_after", busy, 0);
        send(1, 0, 31);
        chk("to_text", text, TB);
        chk("to_key", key, KB);
        chk("to_valid", blk_valid, 1);
        handshake();
        // back-to-back: byte 0 of frame B rides the handshake cycle
        send(0, 0, 31);
        chk("b2b_valid", blk_valid, 1);
        blk_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data = fb[0];
        tick();
        rx_valid = 1'b0;
        blk_ready = 1'b0;
        chk("b2b_flags", {blk_valid, overrun, busy}, 3'b001);
        send(1, 1, 31);
        chk("b2b_text", text, TB);
        chk("b2b_key", key, KB);
        chk("b2b_valid2", blk_valid, 1);
        handshake();
        // reset mid-frame
        send(0, 0, 19);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_text", text, 0);
        chk("mid_rst_key", key, 0);
        chk("mid_rst_flags", {blk_valid, busy, frame_err, overrun}, 0);
        rst = 1'b0;
        send(1, 0, 31);
        chk("post_rst_text", text, TB);
        chk("post_rst_key", key, KB);
        handshake();
        // byte lands exactly on the expiry cycle
        send(1, 0, 4);
        ferr_n = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            ferr_n += int'(frame_err);
        end
        send(1, 5, 5);
        ferr_n += int'(frame_err);
        chk("edge_no_err", ferr_n, 0);
        chk("edge_busy", busy, 1);
        send(1, 6, 31);
        chk("edge_text", text, TB);
        chk("edge_key", key, KB);
        chk("edge_valid", blk_valid, 1);
        handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
